div_16bit: RTL and testbench

- Sequential unsigned integer divider: 16-bit dividend A, 8-bit divisor B.
- Produces a 16-bit quotient (result) and a 16-bit zero-extended remainder (odd).
- Restoring algorithm, one quotient bit per clock, valid/ready handshake on input, single-cycle valid pulse on output.
- Used as a shared arithmetic slave wherever a low-rate 16/8 divide is needed.

---
 rtl/div_16bit_pkg.sv | 23 ++
 rtl/div_16bit_step.sv | 35 +++
 rtl/div_16bit.sv | 111 +++++++++++
 tb/tb_div_16bit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_16bit_pkg.sv
// div_16bit_pkg
//   Shared constants and types for the 16/8 sequential restoring divider.
//   DIVIDEND_W : dividend / quotient width
//   DIVISOR_W  : divisor width
//   REM_W      : partial remainder width (one bit wider than the divisor so
//                the trial value can exceed it before subtraction)
//   ITER_CNT_W : width of the iteration counter (16 iterations -> 4 bits)
package div_16bit_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int REM_W      = 9;
  localparam int ITER_CNT_W = 4;

  // Counter value loaded on acceptance; counts down to zero on the last step.
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/div_16bit_step.sv
// div_16bit_step
//   One combinational restoring-division step.
//   Ports:
//     rem_in  [8:0] : partial remainder from the previous step
//     a_bit         : next dividend bit (MSB first)
//     divisor [7:0] : divisor
//     rem_out [8:0] : partial remainder after this step
//     q_bit         : quotient bit produced by this step
module div_16bit_step
  import div_16bit_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 a_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W-1:0] trial;
  logic [REM_W-1:0] diff;
  logic [REM_W-1:0] divisor_ext;
  logic             unused_rem_msb;

  // For a non-zero divisor the remainder always fits in 8 bits, so only the
  // low bits carry into the trial value. With a zero divisor the top bit is
  // simply discarded, which yields odd = A[7:0].
  assign unused_rem_msb = rem_in[REM_W-1];

  assign divisor_ext = {1'b0, divisor};
  assign trial       = {rem_in[REM_W-2:0], a_bit};
  assign diff        = trial - divisor_ext;
  assign q_bit       = (trial >= divisor_ext);
  assign rem_out     = q_bit ? diff : trial;

endmodule

// File: rtl/div_16bit.sv
// div_16bit
//   Sequential unsigned divider, 16-bit dividend by 8-bit divisor, one
//   quotient bit per clock (restoring). Accepts operands on in_valid &&
//   in_ready, produces a one-cycle out_valid pulse 16 edges later.
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : operands A/B valid
//     in_ready   : divider idle, operands accepted this cycle if in_valid
//     A [15:0]   : dividend
//     B [7:0]    : divisor (B=0 gives result=16'hFFFF, odd=A[7:0])
//     out_valid  : one-cycle pulse, result/odd just updated
//     result     : quotient
//     odd        : zero-extended remainder
//     div_by_zero: (only with DIV_16BIT_DBZ_FLAG_EN) last completed op had B=0
module div_16bit
  import div_16bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  out_valid,
  output logic [DIVIDEND_W-1:0] result,
  output logic [DIVIDEND_W-1:0] odd
`ifdef DIV_16BIT_DBZ_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  state_t                  state;
  state_t                  state_nxt;
  logic [ITER_CNT_W-1:0]   cnt;
  logic [DIVIDEND_W-1:0]   a_sh;
  logic [DIVISOR_W-1:0]    b_reg;
  logic [REM_W-1:0]        rem;
  logic [DIVIDEND_W-1:0]   quot;
  logic [REM_W-1:0]        step_rem;
  logic                    step_q;
  logic                    accept;
  logic                    last_step;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == BUSY) && (cnt == '0);

  div_16bit_step u_step (
    .rem_in  (rem),
    .a_bit   (a_sh[DIVIDEND_W-1]),
    .divisor (b_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_sh      <= '0;
      b_reg     <= '0;
      rem       <= '0;
      quot      <= '0;
      result    <= '0;
      odd       <= '0;
      out_valid <= 1'b0;
`ifdef DIV_16BIT_DBZ_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        a_sh  <= A;
        b_reg <= B;
        rem   <= '0;
        quot  <= '0;
        cnt   <= LAST_ITER;
      end else if (state == BUSY) begin
        a_sh <= {a_sh[DIVIDEND_W-2:0], 1'b0};
        rem  <= step_rem;
        quot <= {quot[DIVIDEND_W-2:0], step_q};
        cnt  <= cnt - 1'b1;
        if (last_step) begin
          result    <= {quot[DIVIDEND_W-2:0], step_q};
          odd       <= {{(DIVIDEND_W-DIVISOR_W){1'b0}}, step_rem[DIVISOR_W-1:0]};
          out_valid <= 1'b1;
`ifdef DIV_16BIT_DBZ_FLAG_EN
          div_by_zero <= (b_reg == '0);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_div_16bit.sv
// tb_div_16bit
//   Self-checking bench for div_16bit. Expected values come from directed
//   constants and plain integer division / modulo. Honours
//   DIV_16BIT_DBZ_FLAG_EN for the optional div_by_zero output.
module tb_div_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic [15:0] result;
  logic [15:0] odd;
`ifdef DIV_16BIT_DBZ_FLAG_EN
  logic        div_by_zero;
`endif

  int total = 0;
  int bad = 0;
  int ov_count = 0;

  div_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .result    (result),
    .odd       (odd)
`ifdef DIV_16BIT_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) ov_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one operation (drives immediately, caller is between edges) and
  // waits, bounded, for out_valid. Does no checking itself.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit noisy,
                        output logic [15:0] r, output logic [15:0] o,
                        output int lat, output bit ready_bad);
    A = a; B = b; in_valid = 1'b1; ready_bad = 1'b0; lat = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (in_ready !== 1'b0) ready_bad = 1'b1;
    while (lat < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        A = 16'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) ready_bad = 1'b1;
    end
    in_valid = 1'b0;
    r = result;
    o = odd;
  endtask

  task automatic test_reset();
    #2;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (odd !== 16'h0000) begin bad++; $display("FAIL reset_odd got=%h want=0000", odd); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
`ifdef DIV_16BIT_DBZ_FLAG_EN
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] r, o; int lat; bit rb;
    run_op(16'hF8E8, 8'hE2, 1'b0, r, o, lat, rb);
    total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
    total++; if (r !== 16'h0119) begin bad++; $display("FAIL basic_result got=%h want=0119", r); end
    total++; if (o !== 16'h00D6) begin bad++; $display("FAIL basic_odd got=%h want=00d6", o); end
    total++; if (rb !== 1'b0) begin bad++; $display("FAIL basic_in_ready_busy got=1 want=0"); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_done got=%b want=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0", out_valid); end
    total++; if (result !== 16'h0119) begin bad++; $display("FAIL basic_hold got=%h want=0119", result); end
  endtask

  task automatic test_small_divisor();
    logic [15:0] r, o; int lat; bit rb;
    run_op(16'h3397, 8'h02, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'h19CB) begin bad++; $display("FAIL small2_result got=%h want=19cb", r); end
    total++; if (o !== 16'h0001) begin bad++; $display("FAIL small2_odd got=%h want=0001", o); end
    @(negedge clk);
    run_op(16'hF778, 8'h03, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'h527D) begin bad++; $display("FAIL small3_result got=%h want=527d", r); end
    total++; if (o !== 16'h0001) begin bad++; $display("FAIL small3_odd got=%h want=0001", o); end
    total++; if (lat !== 16) begin bad++; $display("FAIL small3_latency got=%0d want=16", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, o; int lat; bit rb;
    run_op(16'h031A, 8'hDF, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'h0003) begin bad++; $display("FAIL b2b_first_result got=%h want=0003", r); end
    total++; if (o !== 16'h007D) begin bad++; $display("FAIL b2b_first_odd got=%h want=007d", o); end
    // Still inside the out_valid cycle: issue the next operands now.
    run_op(16'h2CD5, 8'h4B, 1'b0, r, o, lat, rb);
    total++; if (lat !== 16) begin bad++; $display("FAIL b2b_latency got=%0d want=16", lat); end
    total++; if (r !== 16'h0099) begin bad++; $display("FAIL b2b_second_result got=%h want=0099", r); end
    total++; if (o !== 16'h0002) begin bad++; $display("FAIL b2b_second_odd got=%h want=0002", o); end
    total++; if (rb !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_busy got=1 want=0"); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    logic [15:0] r, o; int lat; bit rb;
    run_op(16'h1234, 8'h00, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'hFFFF) begin bad++; $display("FAIL dbz_result got=%h want=ffff", r); end
    total++; if (o !== 16'h0034) begin bad++; $display("FAIL dbz_odd got=%h want=0034", o); end
`ifdef DIV_16BIT_DBZ_FLAG_EN
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_set got=%b want=1", div_by_zero); end
`endif
    @(negedge clk);
    run_op(16'h0064, 8'h07, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'h000E) begin bad++; $display("FAIL dbz_next_result got=%h want=000e", r); end
    total++; if (o !== 16'h0002) begin bad++; $display("FAIL dbz_next_odd got=%h want=0002", o); end
`ifdef DIV_16BIT_DBZ_FLAG_EN
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_flag_clear got=%b want=0", div_by_zero); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r, o, prev; int lat; bit rb; int c0;
    prev = result;
    A = 16'hE2AA; B = 8'h73; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (result !== prev) begin bad++; $display("FAIL mid_hold_busy got=%h want=%h", result, prev); end
    rst_n = 1'b0;
    #1;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL mid_reset_result got=%h want=0000", result); end
    total++; if (odd !== 16'h0000) begin bad++; $display("FAIL mid_reset_odd got=%h want=0000", odd); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_out_valid got=%b want=0", out_valid); end
    c0 = ov_count;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (ov_count !== c0) begin bad++; $display("FAIL mid_no_out_valid got=%0d want=%0d", ov_count, c0); end
    run_op(16'hE2AA, 8'h73, 1'b0, r, o, lat, rb);
    total++; if (r !== 16'h01F8) begin bad++; $display("FAIL mid_reissue_result got=%h want=01f8", r); end
    total++; if (o !== 16'h0042) begin bad++; $display("FAIL mid_reissue_odd got=%h want=0042", o); end
    total++; if (lat !== 16) begin bad++; $display("FAIL mid_reissue_latency got=%0d want=16", lat); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] r, o, a; logic [7:0] b; int lat; bit rb; int c0;
    int exp_q, exp_r;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      exp_q = int'(a) / int'(b);
      exp_r = int'(a) % int'(b);
      c0 = ov_count;
      run_op(a, b, 1'b1, r, o, lat, rb);
      @(negedge clk);
      total++; if (int'(r) !== exp_q || int'(o) !== exp_r) begin
        bad++; $display("FAIL rand_value a=%h b=%h got q=%h r=%h want q=%h r=%h", a, b, r, o, exp_q[15:0], exp_r[15:0]);
      end
      total++; if (int'(r) * int'(b) + int'(o) !== int'(a) || o >= {8'h00, b}) begin
        bad++; $display("FAIL rand_invariant a=%h b=%h got q=%h r=%h", a, b, r, o);
      end
      total++; if (lat !== 16) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d want=16", a, b, lat); end
      total++; if (ov_count - c0 !== 1) begin bad++; $display("FAIL rand_pulse_count got=%0d want=1", ov_count - c0); end
      total++; if (rb !== 1'b0) begin bad++; $display("FAIL rand_in_ready_busy got=1 want=0"); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_divisor();
    test_back_to_back();
    test_div_zero();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
